traffic_ctrl_multi: RTL and testbench

Parametrised multi-phase traffic-light controller. It sequences N vehicle phases round-robin through green, yellow and all-red intervals, with internal cycle-count timers. A latched pedestrian request can shorten green once a minimum green has elapsed, and inserts an exclusive walk interval. A flash (night) mode blinks all yellows. It replaces the single-approach controller-plus-external-timer arrangement with one self-timed block that sits between the pushbutton or mode inputs and the lamp drivers.

---
 rtl/traffic_pkg.sv | 32 +++
 rtl/traffic_ctrl_multi_phase_timer.sv | 17 +
 rtl/traffic_ctrl_multi.sv | 122 ++++++++++++
 tb/tb_traffic_ctrl_multi.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the multi-phase traffic controller: state encoding
// and timer sizing.
package traffic_pkg;

   localparam logic [2:0] ST_ALL_RED = 3'd0;
   localparam logic [2:0] ST_GREEN   = 3'd1;
   localparam logic [2:0] ST_YELLOW  = 3'd2;
   localparam logic [2:0] ST_WALK    = 3'd3;
   localparam logic [2:0] ST_FLASH   = 3'd4;

   typedef enum logic [2:0] {
      S_ALL_RED = ST_ALL_RED,
      S_GREEN   = ST_GREEN,
      S_YELLOW  = ST_YELLOW,
      S_WALK    = ST_WALK,
      S_FLASH   = ST_FLASH
   } state_t;

   // Wide enough to hold the longest interval's last count (max-1), never 0 bits.
   function automatic int timer_width(input int a, input int b, input int c,
                                      input int d, input int e, input int f);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      if (e > m) m = e;
      if (f > m) m = f;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/traffic_ctrl_multi_phase_timer.sv
// Clear-on-entry interval up-counter; the parent compares the count.
module phase_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      count <= '0;
      else if (clr) count <= '0;
      else          count <= count + 1'b1;
   end

endmodule

// File: rtl/traffic_ctrl_multi.sv
// Self-timed round-robin traffic controller with pedestrian pre-emption,
// exclusive walk interval and flashing-yellow night mode.
module traffic_ctrl_multi
   import traffic_pkg::*;
#(
   parameter int N_PHASES    = 2,
   parameter int T_GREEN     = 10,
   parameter int T_MIN_GREEN = 4,
   parameter int T_YELLOW    = 3,
   parameter int T_ALLRED    = 2,
   parameter int T_WALK      = 6,
   parameter int T_FLASH     = 5
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        pedestrian,
   input  logic                        flash_mode,
   output logic [N_PHASES-1:0]         green,
   output logic [N_PHASES-1:0]         yellow,
   output logic [N_PHASES-1:0]         red,
   output logic                        walk,
   output logic                        ped_pending,
   output logic [$clog2(N_PHASES)-1:0] phase
);

   localparam int TW = timer_width(T_GREEN, T_MIN_GREEN, T_YELLOW, T_ALLRED, T_WALK, T_FLASH);
   localparam int PW = $clog2(N_PHASES);

   localparam logic [TW-1:0] G_LAST  = TW'(T_GREEN - 1);
   localparam logic [TW-1:0] MG_LAST = TW'(T_MIN_GREEN - 1);
   localparam logic [TW-1:0] Y_LAST  = TW'(T_YELLOW - 1);
   localparam logic [TW-1:0] AR_LAST = TW'(T_ALLRED - 1);
   localparam logic [TW-1:0] W_LAST  = TW'(T_WALK - 1);
   localparam logic [TW-1:0] F_LAST  = TW'(T_FLASH - 1);
   localparam logic [PW-1:0] PH_LAST = PW'(N_PHASES - 1);

   if (N_PHASES < 2 || T_GREEN < 1 || T_MIN_GREEN < 1 || T_MIN_GREEN > T_GREEN ||
       T_YELLOW < 1 || T_ALLRED < 1 || T_WALK < 1 || T_FLASH < 1) begin : g_param_err
      $error("traffic_ctrl_multi: illegal parameter set");
   end

   state_t        state, nxt;
   logic [TW-1:0] timer;
   logic          blink;
   logic          entering;
   logic          flash_toggle;

   // Flash half-periods reuse the interval timer, restarting it at each toggle.
   assign entering     = (nxt != state);
   assign flash_toggle = (state == S_FLASH) && (timer == F_LAST);

   phase_timer #(.W(TW)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .clr   (entering || flash_toggle),
      .count (timer)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_ALL_RED;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         S_ALL_RED: if (timer == AR_LAST)
                       nxt = flash_mode ? S_FLASH : (ped_pending ? S_WALK : S_GREEN);
         S_GREEN:   if (timer == G_LAST || (ped_pending && timer >= MG_LAST))
                       nxt = S_YELLOW;
         S_YELLOW:  if (timer == Y_LAST) nxt = S_ALL_RED;
         S_WALK:    if (timer == W_LAST) nxt = S_GREEN;
         S_FLASH:   if (!flash_mode) nxt = S_ALL_RED;
         default:   nxt = S_ALL_RED;
      endcase
   end

   // A request arriving on the same edge the walk starts is served by that walk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                   ped_pending <= 1'b0;
      else if (nxt == S_WALK && state != S_WALK) ped_pending <= 1'b0;
      else if (state != S_WALK && pedestrian)    ped_pending <= 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         phase <= PH_LAST;
      else if (nxt == S_GREEN && state != S_GREEN)
         phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                     blink <= 1'b0;
      else if (nxt == S_FLASH && state != S_FLASH) blink <= 1'b1;
      else if (state == S_FLASH && nxt != S_FLASH) blink <= 1'b0;
      else if (flash_toggle)                       blink <= ~blink;
   end

   always_comb begin
      green  = '0;
      yellow = '0;
      red    = '1;
      walk   = 1'b0;
      case (state)
         S_GREEN: begin
            green[phase] = 1'b1;
            red[phase]   = 1'b0;
         end
         S_YELLOW: begin
            yellow[phase] = 1'b1;
            red[phase]    = 1'b0;
         end
         S_WALK:  walk = 1'b1;
         S_FLASH: begin
            red    = '0;
            yellow = {N_PHASES{blink}};
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Directed and randomized checks of traffic_ctrl_multi against an
// interval-age reference model.
module tb_traffic_ctrl_multi;

   localparam int N = 3, TG = 10, TMG = 4, TY = 3, TAR = 2, TWK = 6, TF = 5;
   localparam int M_AR = 0, M_G = 1, M_Y = 2, M_W = 3, M_F = 4;
   localparam int OW = 3 * N + 4;

   logic         clk = 1'b0, rst = 1'b1, pedestrian = 1'b0, flash_mode = 1'b0;
   logic [N-1:0] green, yellow, red;
   logic         walk, ped_pending;
   logic [1:0]   phase;

   int vectors = 0, miscompares = 0, cyc = 0;
   int m_st, m_age, m_phase;
   bit m_pend;

   traffic_ctrl_multi #(
      .N_PHASES(N), .T_GREEN(TG), .T_MIN_GREEN(TMG), .T_YELLOW(TY),
      .T_ALLRED(TAR), .T_WALK(TWK), .T_FLASH(TF)
   ) dut (
      .clk(clk), .rst(rst), .pedestrian(pedestrian), .flash_mode(flash_mode),
      .green(green), .yellow(yellow), .red(red), .walk(walk),
      .ped_pending(ped_pending), .phase(phase)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_st = M_AR; m_age = 1; m_phase = N - 1; m_pend = 1'b0;
   endtask

   // age counts cycles spent in the current interval, starting at 1
   function automatic logic [OW-1:0] expect_out();
      logic [N-1:0] g, y, r;
      logic w;
      g = '0; y = '0; r = '1; w = 1'b0;
      case (m_st)
         M_G: begin g[m_phase] = 1'b1; r[m_phase] = 1'b0; end
         M_Y: begin y[m_phase] = 1'b1; r[m_phase] = 1'b0; end
         M_W: w = 1'b1;
         M_F: begin r = '0; y = ((((m_age - 1) / TF) % 2) == 0) ? '1 : '0; end
         default: ;
      endcase
      return {g, y, r, w, m_pend, 2'(m_phase)};
   endfunction

   task automatic step_model(input bit ped, input bit fm);
      int nx;
      nx = m_st;
      case (m_st)
         M_AR: if (m_age == TAR) nx = fm ? M_F : (m_pend ? M_W : M_G);
         M_G:  if (m_age == TG || (m_pend && m_age >= TMG)) nx = M_Y;
         M_Y:  if (m_age == TY) nx = M_AR;
         M_W:  if (m_age == TWK) nx = M_G;
         M_F:  if (!fm) nx = M_AR;
         default: nx = M_AR;
      endcase
      if (nx == M_W && m_st != M_W)  m_pend = 1'b0;
      else if (m_st != M_W && ped)   m_pend = 1'b1;
      if (nx != m_st) begin
         m_age = 1;
         if (nx == M_G) m_phase = (m_phase + 1) % N;
      end else begin
         m_age++;
      end
      m_st = nx;
   endtask

   task automatic check(input string tag);
      logic [OW-1:0] obs, exp;
      obs = {green, yellow, red, walk, ped_pending, phase};
      exp = expect_out();
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic spot(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   // Called at a negedge: check this cycle, drive inputs, advance one edge.
   task automatic cycle(input bit ped, input bit fm, input string tag);
      check(tag);
      pedestrian = ped; flash_mode = fm;
      @(posedge clk);
      step_model(ped, fm);
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; pedestrian = 1'b0; flash_mode = 1'b0;
      @(negedge clk);
      model_reset();
      check("reset");
      @(negedge clk);
      rst = 1'b0;
      cyc = 0;
   endtask

   initial begin
      bit fm_r, ped_hold;
      model_reset();
      @(negedge clk);

      // no requests: full rotation and wrap
      do_reset();
      for (int i = 0; i < 50; i++) begin
         if (cyc == 0)  spot("red_c0", red, 3'b111);
         if (cyc == 2)  spot("green0_c2", green, 3'b001);
         if (cyc == 12) spot("yellow0_c12", yellow, 3'b001);
         if (cyc == 17) spot("green1_c17", green, 3'b010);
         if (cyc == 32) spot("green2_c32", green, 3'b100);
         if (cyc == 47) spot("green0_wrap", green, 3'b001);
         cycle(1'b0, 1'b0, "idle");
      end

      // pedestrian pulse during min green
      do_reset();
      for (int i = 0; i < 40; i++) begin
         if (cyc == 4)  spot("pend_c4", {2'b0, ped_pending}, 3'b001);
         if (cyc == 6)  spot("yellow_c6", yellow, 3'b001);
         if (cyc == 11) spot("walk_c11", {1'b0, walk, ped_pending}, 3'b010);
         if (cyc == 17) spot("green1_after_walk", green, 3'b010);
         cycle(cyc == 3, 1'b0, "ped_early");
      end

      // pedestrian after min green, then a pulse during walk
      do_reset();
      for (int i = 0; i < 45; i++) begin
         if (cyc == 11) spot("yellow_c11", yellow, 3'b001);
         if (cyc == 37) spot("no_second_walk", green, 3'b100);
         cycle(cyc == 9 || cyc == 18, 1'b0, "ped_late");
      end

      // flash mode
      do_reset();
      for (int i = 0; i < 45; i++) begin
         if (cyc == 11) spot("flash_green_c11", green, 3'b001);
         if (cyc == 17) spot("flash_on_c17", yellow, 3'b111);
         if (cyc == 21) spot("flash_on_c21", yellow, 3'b111);
         if (cyc == 22) spot("flash_off_c22", yellow, 3'b000);
         if (cyc == 26) spot("flash_off_c26", yellow, 3'b000);
         if (cyc == 33) spot("green1_after_flash", green, 3'b010);
         cycle(1'b0, cyc >= 5 && cyc < 30, "flash");
      end

      // asynchronous reset in yellow
      do_reset();
      while (cyc < 13) cycle(1'b0, 1'b0, "pre_rst");
      rst = 1'b1;
      #1;
      model_reset();
      check("async_reset");
      do_reset();
      for (int i = 0; i < 20; i++) begin
         if (cyc == 17) spot("green1_post_rst", green, 3'b010);
         cycle(1'b0, 1'b0, "post_rst");
      end

      // randomized requests, held pedestrian stretches and flash episodes
      do_reset();
      fm_r = 1'b0; ped_hold = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 79) == 0) fm_r = ~fm_r;
         if ($urandom_range(0, 99) == 0) ped_hold = ~ped_hold;
         cycle(ped_hold || ($urandom_range(0, 11) == 0), fm_r, "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
